karatsuba_accumulator: RTL and testbench
========================================

KARATSUBA_ACCUMULATOR -- requirements
Module: karatsuba_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 40, accumulator and result width in bits (legal range 33..64).
REQ-002 SHALL have parameter LEN_W, default 8, width of the burst-length field.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port len, input, LEN_W, number of products in the burst; captured when start is accepted.
REQ-007 SHALL have port prod, input, 32, unsigned product from the upstream 4-digit Karatsuba multiplier.
REQ-008 SHALL have port prod_valid, input, 1, prod is valid this cycle.
REQ-009 SHALL have port prod_ready, output, 1, the block accepts prod this cycle.
REQ-010 SHALL have port acc, output, ACC_W, accumulated sum of the burst.
REQ-011 SHALL have port acc_valid, output, 1, acc holds a completed burst result.
REQ-012 SHALL have port acc_ready, input, 1, the downstream block consumes acc this cycle.
REQ-013 SHALL have port overflow, output, 1, carry out of ACC_W occurred during the current or last burst.
REQ-014 SHALL have port busy, output, 1, the FSM is not in IDLE.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, ACCUM, DONE.
REQ-016 In IDLE with start=1 and len>0: SHALL capture len into a down-counter, clear acc and overflow, and enter ACCUM on the next edge.
REQ-017 In IDLE with start=1 and len=0: SHALL clear acc and overflow and enter DONE directly, with no product consumed.
REQ-018 prod_ready SHALL be 1 exactly when state=ACCUM; it SHALL be 0 in IDLE and DONE.
REQ-019 A product handshake is prod_valid=1 and prod_ready=1 on the same edge; only handshaken beats SHALL modify acc.
REQ-020 On each handshake: acc <= acc + zero-extended prod (modulo 2^ACC_W), and the counter decrements by 1.
REQ-021 A carry out of bit ACC_W-1 on any handshake SHALL set overflow; overflow is sticky until the next accepted start or reset.
REQ-022 The handshake that brings the counter from 1 to 0 SHALL move the FSM to DONE; acc_valid SHALL be 1 in the following cycle (latency 1 from last beat).
REQ-023 prod_valid gaps (bubbles) in ACCUM SHALL stall the FSM with acc and counter unchanged.
REQ-024 In DONE, acc_valid SHALL be 1, and acc and overflow SHALL stay stable until acc_ready=1.
REQ-025 acc_valid and acc_ready both 1 SHALL return the FSM to IDLE on that edge; acc SHALL retain its value in IDLE.
REQ-026 start asserted in ACCUM or DONE SHALL be ignored, with no queuing.
REQ-027 start asserted in the same cycle as the DONE->IDLE handshake SHALL be ignored; it is accepted only from the IDLE state.
REQ-028 busy SHALL be 1 in ACCUM and DONE.

Reset
REQ-029 rst=1 SHALL asynchronously force: state=IDLE, acc=0, counter=0, overflow=0, acc_valid=0, prod_ready=0, busy=0.
REQ-030 Reset mid-burst (ACCUM or DONE) SHALL abandon the burst; no partial result SHALL be presented after reset deasserts.
REQ-031 After rst deasserts, the first start SHALL be accepted on the first rising edge with rst=0.

Structure
REQ-032 A shared package SHALL hold the FSM state enumeration (IDLE=0, ACCUM=1, DONE=2, 2-bit encoding) and the default ACC_W/LEN_W constants.
REQ-033 The block SHALL be a single module with no sub-modules; the product arrives precomputed and the multiplier is not instantiated here.
REQ-034 The block SHALL contain no combinational path from prod_valid to prod_ready, or from acc_ready to acc_valid.

Verification
REQ-035 Stimulus: start with len=3; products 1234*5678=7006652, 9999*9999=99980001, 1*1=1, all back-to-back. Required response: acc=106986654, acc_valid one cycle after the third beat, overflow=0.
REQ-036 Stimulus: len=2 with a 3-cycle prod_valid bubble between beats (products 10 and 20), and acc_ready held low for 4 cycles. Required response: acc=30 held stable with acc_valid=1 throughout; return to IDLE on acc_ready.
REQ-037 Stimulus: ACC_W=33, len=3, each prod=0xFFFFFFFF. Required response: acc=0x0FFFFFFFD (the third beat wraps modulo 2^33), overflow=1.
REQ-038 Stimulus: start with len=0. Required response: acc=0 and acc_valid=1 on the next cycle; prod_ready never asserts.
REQ-039 Stimulus: rst pulsed after 2 of 5 beats, then a new burst with len=1, prod=42. Required response: all outputs at reset values immediately; new result acc=42, overflow=0.
REQ-040 Stimulus: start asserted during ACCUM and during DONE. Required response: ignored; counter, acc and state are unaffected.

Source files
------------

// File: rtl/karatsuba_accumulator_pkg.sv
// karatsuba_accumulator_pkg: shared FSM encoding and default widths
package karatsuba_accumulator_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;
    localparam int ACC_W_DEF = 40;
    localparam int LEN_W_DEF = 8;
endpackage

// File: rtl/karatsuba_accumulator.sv
// karatsuba_accumulator: sums a burst of 32-bit products with sticky carry-out flag
module karatsuba_accumulator
    import karatsuba_accumulator_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             overflow,
    output logic             busy
);
    state_t           state, state_n;
    logic [LEN_W-1:0] count;
    logic [ACC_W:0]   sum;
    logic             beat;
    logic             accept;

    assign accept     = (state == IDLE) && start;
    assign beat       = (state == ACCUM) && prod_valid;
    assign sum        = {1'b0, acc} + {{(ACC_W + 1 - 32){1'b0}}, prod};
    assign prod_ready = (state == ACCUM);
    assign acc_valid  = (state == DONE);
    assign busy       = (state != IDLE);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next state: a zero-length burst skips straight to DONE; last beat ends ACCUM
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? ((len != '0) ? ACCUM : DONE) : IDLE;
            ACCUM:   state_n = (prod_valid && count == LEN_W'(1)) ? DONE : ACCUM;
            DONE:    state_n = acc_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    // datapath: clear on accepted start, accumulate and count down on each beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            acc      <= '0;
            count    <= len;
            overflow <= 1'b0;
        end else if (beat) begin
            acc      <= sum[ACC_W-1:0];
            count    <= count - LEN_W'(1);
            overflow <= overflow | sum[ACC_W];
        end
    end
endmodule

// File: tb/tb_karatsuba_accumulator.sv
// tb_karatsuba_accumulator: directed bursts checked against a transaction-level model
module tb_karatsuba_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic [31:0] prod = '0;
    logic        prod_valid = 1'b0;
    logic        acc_ready = 1'b0;

    logic        prod_ready_a, acc_valid_a, overflow_a, busy_a;
    logic [39:0] acc_a;
    logic        prod_ready_b, acc_valid_b, overflow_b, busy_b;
    logic [32:0] acc_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    karatsuba_accumulator #(.ACC_W(40), .LEN_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(prod_ready_a), .acc(acc_a),
        .acc_valid(acc_valid_a), .acc_ready(acc_ready), .overflow(overflow_a),
        .busy(busy_a)
    );

    karatsuba_accumulator #(.ACC_W(33), .LEN_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(prod_ready_b), .acc(acc_b),
        .acc_valid(acc_valid_b), .acc_ready(acc_ready), .overflow(overflow_b),
        .busy(busy_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: phase 0 = waiting for start, 1 = collecting beats, 2 = result held
    int          m_phase = 0;
    int          m_left = 0;
    longint      m_sum [2];
    logic        m_ovf [2];
    int          widths [2] = '{40, 33};

    initial begin
        m_sum = '{0, 0};
        m_ovf = '{1'b0, 1'b0};
    end

    always @(negedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_left  = 0;
            m_sum   = '{0, 0};
            m_ovf   = '{1'b0, 1'b0};
        end
        chk("prod_ready_a", 64'(prod_ready_a), 64'(m_phase == 1));
        chk("acc_valid_a",  64'(acc_valid_a),  64'(m_phase == 2));
        chk("busy_a",       64'(busy_a),       64'(m_phase != 0));
        chk("acc_a",        64'(acc_a),        m_sum[0]);
        chk("overflow_a",   64'(overflow_a),   64'(m_ovf[0]));
        chk("prod_ready_b", 64'(prod_ready_b), 64'(m_phase == 1));
        chk("acc_valid_b",  64'(acc_valid_b),  64'(m_phase == 2));
        chk("busy_b",       64'(busy_b),       64'(m_phase != 0));
        chk("acc_b",        64'(acc_b),        m_sum[1]);
        chk("overflow_b",   64'(overflow_b),   64'(m_ovf[1]));
        if (!rst) begin
            if (m_phase == 0 && start) begin
                m_left  = int'(len);
                m_sum   = '{0, 0};
                m_ovf   = '{1'b0, 1'b0};
                m_phase = (len != 0) ? 1 : 2;
            end else if (m_phase == 1 && prod_valid) begin
                for (int i = 0; i < 2; i++) begin
                    longint full;
                    full = m_sum[i] + longint'(prod);
                    if ((full >> widths[i]) != 0) m_ovf[i] = 1'b1;
                    m_sum[i] = full & ((64'sd1 <<< widths[i]) - 1);
                end
                m_left--;
                if (m_left == 0) m_phase = 2;
            end else if (m_phase == 2 && acc_ready) begin
                m_phase = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] p);
        prod = p;
        prod_valid = 1'b1;
        step();
        prod_valid = 1'b0;
    endtask

    task automatic ack();
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
        chk("idle_after_ack", 64'(busy_a), 64'd0);
    endtask

    initial begin
        step();
        step();
        chk("reset_acc", 64'(acc_a), 64'd0);
        chk("reset_busy", 64'(busy_a), 64'd0);
        rst = 1'b0;

        // three back-to-back Karatsuba products
        start = 1'b1; len = 8'd3;
        step();
        start = 1'b0;
        prod_valid = 1'b1;
        prod = 32'd7006652;  step();
        prod = 32'd99980001; step();
        prod = 32'd1;        step();
        prod_valid = 1'b0;
        chk("sum3_valid", 64'(acc_valid_a), 64'd1);
        chk("sum3_acc", 64'(acc_a), 64'd106986654);
        chk("sum3_ovf", 64'(overflow_a), 64'd0);
        ack();
        chk("sum3_retained", 64'(acc_a), 64'd106986654);

        // bubbles between beats and a slow consumer
        start = 1'b1; len = 8'd2;
        step();
        start = 1'b0;
        beat(32'd10);
        step(); step(); step();
        chk("bubble_acc", 64'(acc_a), 64'd10);
        beat(32'd20);
        for (int i = 0; i < 4; i++) begin
            chk("hold_valid", 64'(acc_valid_a), 64'd1);
            chk("hold_acc", 64'(acc_a), 64'd30);
            step();
        end
        ack();

        // wrap in the 33-bit instance
        start = 1'b1; len = 8'd3;
        step();
        start = 1'b0;
        beat(32'hFFFF_FFFF);
        chk("wrap_no_ovf_yet", 64'(overflow_b), 64'd0);
        beat(32'hFFFF_FFFF);
        beat(32'hFFFF_FFFF);
        chk("wrap33_acc", 64'(acc_b), 64'h0_FFFF_FFFD);
        chk("wrap33_ovf", 64'(overflow_b), 64'd1);
        chk("wrap40_acc", 64'(acc_a), 64'h2_FFFF_FFFD);
        chk("wrap40_ovf", 64'(overflow_a), 64'd0);
        ack();
        chk("ovf_sticky_idle", 64'(overflow_b), 64'd1);

        // zero-length burst
        start = 1'b1; len = 8'd0;
        step();
        start = 1'b0;
        chk("len0_valid", 64'(acc_valid_a), 64'd1);
        chk("len0_acc", 64'(acc_b), 64'd0);
        chk("len0_ovf_cleared", 64'(overflow_b), 64'd0);
        chk("len0_ready", 64'(prod_ready_a), 64'd0);
        ack();

        // reset mid-burst, then restart on the first clean edge
        start = 1'b1; len = 8'd5;
        step();
        start = 1'b0;
        beat(32'd100);
        beat(32'd100);
        rst = 1'b1;
        #1;
        chk("rst_acc", 64'(acc_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_ready", 64'(prod_ready_a), 64'd0);
        step();
        rst = 1'b0; start = 1'b1; len = 8'd1;
        step();
        start = 1'b0;
        chk("restart_accum", 64'(prod_ready_a), 64'd1);
        beat(32'd42);
        chk("restart_acc", 64'(acc_a), 64'd42);
        chk("restart_ovf", 64'(overflow_a), 64'd0);
        chk("restart_valid", 64'(acc_valid_a), 64'd1);

        // start ignored in DONE, in ACCUM, and on the DONE->IDLE edge
        start = 1'b1; len = 8'd9;
        step();
        chk("start_in_done", 64'(acc_a), 64'd42);
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
        chk("start_on_ack", 64'(busy_a), 64'd0);
        len = 8'd2;
        step();
        len = 8'd7;
        step();
        prod = 32'd5; prod_valid = 1'b1;
        step();
        prod = 32'd6;
        step();
        prod_valid = 1'b0;
        chk("ignore_acc", 64'(acc_a), 64'd11);
        chk("ignore_done", 64'(acc_valid_a), 64'd1);
        step();
        chk("ignore_still_done", 64'(acc_valid_a), 64'd1);
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
        start = 1'b0;
        chk("ignore_idle", 64'(busy_a), 64'd0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
